pos_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises two 4-input single-output combinational function units (a canonical product-of-sums and its simplified form), both driven from a shared input vector. It steps the vector 0..15, samples both outputs, builds their truth tables and reports equivalence. It is the on-chip equivalent of the team's manual truth-table sweep benches.

---
 rtl/pos_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_pos_sweep_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_sweep_ctrl.sv
// pos_sweep_ctrl: steps a shared 4-bit vector through 0..15 for two
// combinational function units (canonical S1 and simplified S2). It holds
// each vector for HOLD_CYCLES cycles and samples both outputs at the end of
// the hold window. It builds both truth tables, counts disagreements and
// reports equivalence.
// Optional macro GOLDEN_CHECK_EN: compares the final table1 against GOLDEN_TT
// and reports the result on golden_err. Without it, golden_err is tied low.
module pos_sweep_ctrl #(
    parameter int          HOLD_CYCLES = 1,
    parameter logic [15:0] GOLDEN_TT   = 16'h74EF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        S1,
    input  logic        S2,
    output logic [3:0]  vec,
    output logic        busy,
    output logic        done,
    output logic [15:0] table1,
    output logic [15:0] table2,
    output logic [4:0]  mism_cnt,
    output logic [3:0]  first_mism,
    output logic        first_valid,
    output logic        match,
    output logic        golden_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    logic       sample_edge;
    logic       mism_now;
    logic [4:0] mism_next;

    // An abort on the last hold cycle wins, so that vector is never sampled.
    assign sample_edge = (state == APPLY) && !abort && (hold_cnt == HOLD_LAST);
    assign mism_now    = S1 ^ S2;
    assign mism_next   = mism_cnt + {4'd0, mism_now};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Sweep sequencer: accepts start, holds and samples each vector, and
    // accumulates the truth tables and mismatch statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            vec         <= 4'd0;
            hold_cnt    <= 4'd0;
            table1      <= 16'd0;
            table2      <= 16'd0;
            mism_cnt    <= 5'd0;
            first_mism  <= 4'd0;
            first_valid <= 1'b0;
            match       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= APPLY;
                        vec         <= 4'd0;
                        hold_cnt    <= 4'd0;
                        table1      <= 16'd0;
                        table2      <= 16'd0;
                        mism_cnt    <= 5'd0;
                        first_mism  <= 4'd0;
                        first_valid <= 1'b0;
                        match       <= 1'b0;
                    end
                end
                APPLY: begin
                    if (abort) begin
                        state    <= IDLE;
                        vec      <= 4'd0;
                        hold_cnt <= 4'd0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end else begin
                        table1[vec] <= S1;
                        table2[vec] <= S2;
                        if (mism_now) begin
                            mism_cnt <= mism_next;
                            if (!first_valid) begin
                                first_mism  <= vec;
                                first_valid <= 1'b1;
                            end
                        end
                        if (vec == 4'd15) begin
                            state <= DONE;
                            match <= (mism_next == 5'd0);
                        end else begin
                            vec      <= vec + 4'd1;
                            hold_cnt <= 4'd0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GOLDEN_CHECK_EN
    logic golden_q;

    // Golden comparison of the final table1, with the last S1 sample merged in
    // because it lands in table1 on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            golden_q <= 1'b0;
        end else if ((state == IDLE) && start) begin
            golden_q <= 1'b0;
        end else if (sample_edge && (vec == 4'd15)) begin
            golden_q <= ({S1, table1[14:0]} != GOLDEN_TT);
        end
    end

    assign golden_err = golden_q;
`else
    logic unused_golden;

    assign unused_golden = ^GOLDEN_TT ^ sample_edge;
    assign golden_err    = 1'b0;
`endif

endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// tb_pos_sweep_ctrl: runs two sweep controllers (HOLD_CYCLES 1 and 3) against
// function units modelled as truth-table lookups of the DUT vector. A
// sweep-level model predicts every output on every cycle. Directed phases
// pin the model with hand-computed values. A random phase then mixes start,
// abort, reset and truth-table changes.
module tb_pos_sweep_ctrl;

    localparam logic [15:0] GOLD = 16'h74EF;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic [15:0] tt1;
    logic [15:0] tt2;

    logic [3:0]  vec         [2];
    logic        busy        [2];
    logic        done        [2];
    logic [15:0] table1      [2];
    logic [15:0] table2      [2];
    logic [4:0]  mism_cnt    [2];
    logic [3:0]  first_mism  [2];
    logic        first_valid [2];
    logic        match       [2];
    logic        golden_err  [2];
    logic        s1          [2];
    logic        s2          [2];

    int hold [2] = '{1, 3};

    int checks   = 0;
    int failures = 0;

    // Sweep-level model state: sweep in progress, cycles since start,
    // and the results each controller should expose.
    logic        m_act   [2] = '{0, 0};
    logic        m_dn    [2] = '{0, 0};
    int          m_t     [2] = '{0, 0};
    logic [3:0]  m_vec   [2] = '{0, 0};
    logic [15:0] m_t1    [2] = '{0, 0};
    logic [15:0] m_t2    [2] = '{0, 0};
    logic [4:0]  m_cnt   [2] = '{0, 0};
    logic [3:0]  m_fm    [2] = '{0, 0};
    logic        m_fv    [2] = '{0, 0};
    logic        m_match [2] = '{0, 0};
    logic        m_gold  [2] = '{0, 0};

    always #5 clk = ~clk;

    assign s1[0] = tt1[vec[0]];
    assign s2[0] = tt2[vec[0]];
    assign s1[1] = tt1[vec[1]];
    assign s2[1] = tt2[vec[1]];

    pos_sweep_ctrl #(.HOLD_CYCLES(1), .GOLDEN_TT(GOLD)) dut_h1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .S1(s1[0]), .S2(s2[0]), .vec(vec[0]), .busy(busy[0]), .done(done[0]),
        .table1(table1[0]), .table2(table2[0]), .mism_cnt(mism_cnt[0]),
        .first_mism(first_mism[0]), .first_valid(first_valid[0]),
        .match(match[0]), .golden_err(golden_err[0])
    );

    pos_sweep_ctrl #(.HOLD_CYCLES(3), .GOLDEN_TT(GOLD)) dut_h3 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .S1(s1[1]), .S2(s2[1]), .vec(vec[1]), .busy(busy[1]), .done(done[1]),
        .table1(table1[1]), .table2(table2[1]), .mism_cnt(mism_cnt[1]),
        .first_mism(first_mism[1]), .first_valid(first_valid[1]),
        .match(match[1]), .golden_err(golden_err[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic goldenExpect(input logic [15:0] t);
`ifdef GOLDEN_CHECK_EN
        return (t != GOLD);
`else
        return 1'b0;
`endif
    endfunction

    // One clock of the sweep model. Elapsed hold time decides which vector is
    // sampled and when the sweep ends.
    task automatic modelStep(input int i);
        int k;
        if (reset) begin
            m_act[i] = 0; m_dn[i] = 0; m_t[i] = 0; m_vec[i] = 0;
            m_t1[i] = 0; m_t2[i] = 0; m_cnt[i] = 0; m_fm[i] = 0;
            m_fv[i] = 0; m_match[i] = 0; m_gold[i] = 0;
        end else if (m_dn[i]) begin
            m_dn[i] = 0;
        end else if (!m_act[i]) begin
            if (start) begin
                m_act[i] = 1; m_t[i] = 0; m_vec[i] = 0;
                m_t1[i] = 0; m_t2[i] = 0; m_cnt[i] = 0; m_fm[i] = 0;
                m_fv[i] = 0; m_match[i] = 0; m_gold[i] = 0;
            end
        end else if (abort) begin
            m_act[i] = 0;
            m_vec[i] = 0;
        end else begin
            m_t[i]++;
            if (m_t[i] % hold[i] == 0) begin
                k = m_t[i] / hold[i] - 1;
                m_t1[i][k] = tt1[k];
                m_t2[i][k] = tt2[k];
                if (tt1[k] != tt2[k]) begin
                    m_cnt[i]++;
                    if (!m_fv[i]) begin
                        m_fm[i] = 4'(k);
                        m_fv[i] = 1;
                    end
                end
                if (k == 15) begin
                    m_act[i]   = 0;
                    m_dn[i]    = 1;
                    m_match[i] = (m_cnt[i] == 0);
                    m_gold[i]  = goldenExpect(m_t1[i]);
                end else begin
                    m_vec[i] = 4'(k + 1);
                end
            end
        end
    endtask

    // Advance the model on the same edge the DUTs see.
    always @(posedge clk) begin
        modelStep(0);
        modelStep(1);
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("h%0d.vec", hold[i]), 32'(vec[i]), 32'(m_vec[i]));
            checkOutput($sformatf("h%0d.busy", hold[i]), 32'(busy[i]), 32'(m_act[i] | m_dn[i]));
            checkOutput($sformatf("h%0d.done", hold[i]), 32'(done[i]), 32'(m_dn[i]));
            checkOutput($sformatf("h%0d.table1", hold[i]), 32'(table1[i]), 32'(m_t1[i]));
            checkOutput($sformatf("h%0d.table2", hold[i]), 32'(table2[i]), 32'(m_t2[i]));
            checkOutput($sformatf("h%0d.mism_cnt", hold[i]), 32'(mism_cnt[i]), 32'(m_cnt[i]));
            checkOutput($sformatf("h%0d.first_mism", hold[i]), 32'(first_mism[i]), 32'(m_fm[i]));
            checkOutput($sformatf("h%0d.first_valid", hold[i]), 32'(first_valid[i]), 32'(m_fv[i]));
            checkOutput($sformatf("h%0d.match", hold[i]), 32'(match[i]), 32'(m_match[i]));
            checkOutput($sformatf("h%0d.golden_err", hold[i]), 32'(golden_err[i]), 32'(m_gold[i]));
        end
    end

    // Start pulse sampled at the next rising edge. Returns on the falling
    // edge right after that edge (edge 0).
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int  done_edge [2];
        int  done_seen;
        logic exp_gold;

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tt1   = GOLD;
        tt2   = GOLD;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset.busy", 32'(busy[0]), 32'd0);
        checkOutput("reset.table1", 32'(table1[1]), 32'd0);

        // Both units correct.
        applyStimulus();
        repeat (60) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("p1.table1", 32'(table1[i]), 32'h74EF);
            checkOutput("p1.table2", 32'(table2[i]), 32'h74EF);
            checkOutput("p1.mism_cnt", 32'(mism_cnt[i]), 32'd0);
            checkOutput("p1.first_valid", 32'(first_valid[i]), 32'd0);
            checkOutput("p1.match", 32'(match[i]), 32'd1);
        end

        // S2 stuck at 1.
        tt2 = 16'hFFFF;
        applyStimulus();
        repeat (60) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("p2.table2", 32'(table2[i]), 32'hFFFF);
            checkOutput("p2.mism_cnt", 32'(mism_cnt[i]), 32'd5);
            checkOutput("p2.first_mism", 32'(first_mism[i]), 32'd4);
            checkOutput("p2.first_valid", 32'(first_valid[i]), 32'd1);
            checkOutput("p2.match", 32'(match[i]), 32'd0);
        end

        // Timing, with a second start at edge 10 that must be ignored.
        tt2 = GOLD;
        done_edge = '{-1, -1};
        applyStimulus();
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = (n == 9);
            if (n == 10) begin
                checkOutput("p3.vec_h1_e10", 32'(vec[0]), 32'd10);
                checkOutput("p3.vec_h3_e10", 32'(vec[1]), 32'd3);
            end
            if (n == 48) checkOutput("p3.busy_h3_e48", 32'(busy[1]), 32'd1);
            if (n == 49) checkOutput("p3.busy_h3_e49", 32'(busy[1]), 32'd0);
            for (int i = 0; i < 2; i++)
                if (done[i] && done_edge[i] < 0) done_edge[i] = n;
        end
        checkOutput("p3.done_edge_h1", 32'(done_edge[0]), 32'd16);
        checkOutput("p3.done_edge_h3", 32'(done_edge[1]), 32'd48);

        // Abort sampled at edge 6.
        done_seen = 0;
        applyStimulus();
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            abort = (n == 5);
            if (n == 6) begin
                checkOutput("p4.busy", 32'(busy[0]), 32'd0);
                checkOutput("p4.vec", 32'(vec[0]), 32'd0);
                checkOutput("p4.table1_lo", 32'(table1[0][4:0]), 32'h0F);
                checkOutput("p4.table1_h3", 32'(table1[1]), 32'h0001);
            end
            if (done[0] || done[1]) done_seen++;
        end
        checkOutput("p4.no_done", 32'(done_seen), 32'd0);
        applyStimulus();
        repeat (60) @(negedge clk);
        checkOutput("p4.restart_table1", 32'(table1[0]), 32'h74EF);
        checkOutput("p4.restart_match", 32'(match[1]), 32'd1);

        // Reset sampled at edge 7 in mid-sweep, restart at edge 9.
        applyStimulus();
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            reset = (n == 6);
            start = (n == 8);
            if (n == 7) begin
                checkOutput("p5.vec", 32'(vec[0]), 32'd0);
                checkOutput("p5.busy", 32'(busy[0]), 32'd0);
                checkOutput("p5.table1", 32'(table1[0]), 32'd0);
                checkOutput("p5.mism_cnt", 32'(mism_cnt[1]), 32'd0);
            end
        end
        checkOutput("p5.table1_after", 32'(table1[0]), 32'h74EF);
        checkOutput("p5.match_after", 32'(match[1]), 32'd1);

        // Units agree but S1 differs from the golden table at index 0.
        tt1 = 16'h74EE;
        tt2 = 16'h74EE;
`ifdef GOLDEN_CHECK_EN
        exp_gold = 1'b1;
`else
        exp_gold = 1'b0;
`endif
        applyStimulus();
        repeat (60) @(negedge clk);
        checkOutput("p6.match", 32'(match[0]), 32'd1);
        checkOutput("p6.golden_err", 32'(golden_err[0]), 32'(exp_gold));
        checkOutput("p6.golden_err_h3", 32'(golden_err[1]), 32'(exp_gold));

        // Random mix of start, abort, reset and unit behaviour.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) begin
                tt1 = 16'($urandom);
                case ($urandom_range(0, 2))
                    0:       tt2 = tt1;
                    1:       tt2 = tt1 ^ (16'd1 << $urandom_range(0, 15));
                    default: tt2 = 16'($urandom);
                endcase
            end
        end

        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
